// File: rtl/branch_predict_unit.sv
// E-stage branch resolution plus a direct-mapped BHT of 2-bit saturating counters for D-stage prediction.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_unit #(
    parameter int         BHT_DEPTH = 64,
    parameter int         PC_W      = 32,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         PERF_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PC_W-1:0]   i_pc_d,
    output logic              o_pred_taken_d,
    input  logic [PC_W-1:0]   i_pc_e,
    input  logic              i_valid_e,
    input  logic              i_stall_e,
    input  logic              i_branch_e,
    input  logic [2:0]        i_f3_e,
    input  logic              i_zero_e,
    input  logic              i_alu_out_lsb_e,
    input  logic              i_pred_taken_e,
    output logic              o_branch_taken_e,
    output logic              o_mispredict_e,
    output logic [PERF_W-1:0] o_perf_branches,
    output logic [PERF_W-1:0] o_perf_mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    generate
        if (BHT_DEPTH < 4 || BHT_DEPTH > 1024 || (BHT_DEPTH & (BHT_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("branch_predict_unit: BHT_DEPTH must be a power of 2 in 4..1024");
        end
    endgenerate

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e;
    logic             cond_met;
    logic             branch_live;
    logic             update_en;
    logic [1:0]       ctr_e;
    logic [1:0]       ctr_upd;
    logic             unused_pc_bits;

    assign idx_d = i_pc_d[IDX_W+1:2];
    assign idx_e = i_pc_e[IDX_W+1:2];
    assign unused_pc_bits = ^{i_pc_d[PC_W-1:IDX_W+2], i_pc_d[1:0],
                              i_pc_e[PC_W-1:IDX_W+2], i_pc_e[1:0]};

    // D reads the registered table directly, so a same-cycle E update is not visible.
    assign o_pred_taken_d = bht_q[idx_d][1];

    always_comb begin
        cond_met = 1'b0;
        case (i_f3_e)
            3'b000:          cond_met = i_zero_e;
            3'b001:          cond_met = ~i_zero_e;
            3'b100, 3'b110:  cond_met = i_alu_out_lsb_e;
            3'b101, 3'b111:  cond_met = ~i_alu_out_lsb_e;
            default:         cond_met = 1'b0;
        endcase
    end

    assign branch_live      = i_valid_e & i_branch_e;
    assign o_branch_taken_e = branch_live & cond_met;
    assign o_mispredict_e   = branch_live & (o_branch_taken_e ^ i_pred_taken_e);
    assign update_en        = branch_live & ~i_stall_e;

    assign ctr_e = bht_q[idx_e];

    always_comb begin
        ctr_upd = ctr_e;
        if (o_branch_taken_e) begin
            if (ctr_e != 2'b11) ctr_upd = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_upd = ctr_e - 2'd1;
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (update_en) bht_d[idx_e] = ctr_upd;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
        end else begin
            bht_q <= bht_d;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_br_d;
    logic [PERF_W-1:0] perf_mp_q;
    logic [PERF_W-1:0] perf_mp_d;

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (update_en) begin
            perf_br_d = perf_br_q + 1'b1;
            if (o_mispredict_e) perf_mp_d = perf_mp_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign o_perf_branches    = perf_br_q;
    assign o_perf_mispredicts = perf_mp_q;
`else
    assign o_perf_branches    = '0;
    assign o_perf_mispredicts = '0;
`endif

endmodule
